// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time in enabled clock cycles.
// One result per period (or per stuck timeout) with a one-cycle strobe.
module pwm_capture #(
  parameter int CNT_BITWIDTH = 9,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic                    pwm_i,
  input  logic [CNT_BITWIDTH-1:0] timeout_i,
  output logic [CNT_BITWIDTH-1:0] periodCount_o,
  output logic [CNT_BITWIDTH-1:0] highCount_o,
  output logic                    dataVaild_STRB_o,
  output logic                    stuckLow_o,
  output logic                    stuckHigh_o
);

  localparam logic [CNT_BITWIDTH-1:0] ONE     = CNT_BITWIDTH'(1);
  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    pwm_s, pwm_prev;
  logic                    rise, tmo;
  logic [CNT_BITWIDTH-1:0] cnt, hcnt, cnt_nxt, hcnt_nxt, cnt_inc, hcnt_inc;
  logic                    rpt_edge, rpt_to;
  logic                    strb_pend;

  assign pwm_s    = sync_q[SYNC_STAGES-1];
  assign rise     = clk_en_i & pwm_s & ~pwm_prev;
  // An edge in the same cycle as the timeout wins.
  assign tmo      = clk_en_i & ~rise & (timeout_i != '0) & (cnt == timeout_i);
  assign cnt_inc  = (cnt  == CNT_MAX) ? cnt  : cnt  + ONE;
  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + ONE;

  // Synchronizer chain on the asynchronous PWM input, runs every clock.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, counter updates and result-load decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    rpt_edge  = 1'b0;
    rpt_to    = 1'b0;
    if (clk_en_i) begin
      cnt_nxt  = cnt_inc;
      hcnt_nxt = pwm_s ? hcnt_inc : hcnt;
      if (rise) begin
        cnt_nxt   = ONE;
        hcnt_nxt  = ONE;
        rpt_edge  = (state == MEASURE);
        state_nxt = MEASURE;
      end else if (tmo) begin
        cnt_nxt   = ONE;
        hcnt_nxt  = CNT_BITWIDTH'(pwm_s);
        rpt_to    = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  // Counters, edge reference, result registers and strobe pending flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pwm_prev      <= 1'b0;
      cnt           <= '0;
      hcnt          <= '0;
      periodCount_o <= '0;
      highCount_o   <= '0;
      stuckLow_o    <= 1'b0;
      stuckHigh_o   <= 1'b0;
      strb_pend     <= 1'b0;
    end else begin
      if (clk_en_i) pwm_prev <= pwm_s;
      cnt  <= cnt_nxt;
      hcnt <= hcnt_nxt;
      // Pending survives disabled cycles so the strobe only shows when enabled.
      strb_pend <= (strb_pend & ~clk_en_i) | rpt_edge | rpt_to;
      if (rpt_edge) begin
        periodCount_o <= cnt;
        highCount_o   <= hcnt;
        stuckLow_o    <= 1'b0;
        stuckHigh_o   <= 1'b0;
      end else if (rpt_to) begin
        periodCount_o <= timeout_i;
        highCount_o   <= pwm_s ? timeout_i : '0;
        stuckLow_o    <= ~pwm_s;
        stuckHigh_o   <= pwm_s;
      end
    end
  end

  // With the enable held high this is just the registered pulse; when the
  // enable drops, the pulse waits for the next enabled cycle.
  assign dataVaild_STRB_o = strb_pend & clk_en_i;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus with a scoreboard of expected results.
module tb_pwm_capture;
  localparam int W = 9;

  logic         clk = 1'b0, rstn = 1'b0, clk_en = 1'b1, pwm = 1'b0;
  logic [W-1:0] timeout = W'(400);
  logic [W-1:0] period_cnt, high_cnt;
  logic         strobe, stuck_lo, stuck_hi;

  pwm_capture #(.CNT_BITWIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .pwm_i(pwm),
    .timeout_i(timeout), .periodCount_o(period_cnt), .highCount_o(high_cnt),
    .dataVaild_STRB_o(strobe), .stuckLow_o(stuck_lo), .stuckHigh_o(stuck_hi)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int p; int h; bit sl; bit sh; bit dc; int ecyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  bit gate = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (gate) clk_en = ~clk_en;
  endtask

  task automatic push(input int p, input int h, input bit sl, input bit sh,
                      input bit dc, input int ecyc);
    exp_t e;
    e.p = p; e.h = h; e.sl = sl; e.sh = sh; e.dc = dc; e.ecyc = ecyc;
    sb.push_back(e);
  endtask

  // One PWM period of p clocks, h high; the rise reports the previous period.
  task automatic pwm_cyc(input int p, input int h, input bit do_push, input bit dc,
                         input int ep, input int eh, input bit timed);
    pwm = 1'b1;
    if (do_push) push(ep, eh, 1'b0, 1'b0, dc, timed ? cyc + 3 : -1);
    repeat (h) step();
    pwm = 1'b0;
    repeat (p - h) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_high"},   high_cnt,   0);
    chk({tag, "_strobe"}, strobe,     0);
    chk({tag, "_stklo"},  stuck_lo,   0);
    chk({tag, "_stkhi"},  stuck_hi,   0);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (strobe === 1'b1) begin
      chk("strb_en", clk_en, 1);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexp_strb: got strobe at cyc %0d want none", cyc);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (!mon_e.dc) begin
          chk("period", period_cnt, mon_e.p);
          chk("high",   high_cnt,   mon_e.h);
          chk("stklo",  stuck_lo,   mon_e.sl);
          chk("stkhi",  stuck_hi,   mon_e.sh);
        end
        if (mon_e.ecyc >= 0) chk("latency", cyc, mon_e.ecyc);
      end
    end
  end

  initial begin
    #(100 * 30000);
    $fatal(1, "FAIL watchdog: got no finish want finish");
  end

  initial begin
    int j;
    // Reset and arm
    repeat (3) step();
    chk_zero("rst");
    rstn = 1'b1;
    pwm_cyc(320, 100, 0, 0, 0, 0, 0);
    // Steady PWM 320/100
    repeat (3) pwm_cyc(320, 100, 1, 0, 320, 100, 1);

    // Stuck high at timeout 50, then resume
    j = cyc;
    timeout = W'(50);
    pwm = 1'b1;
    push(320, 100, 0, 0, 0, j + 3);
    push(50, 50, 0, 1, 0, j + 53);
    push(50, 50, 0, 1, 0, j + 103);
    push(50, 50, 0, 1, 0, j + 153);
    repeat (180) step();
    pwm = 1'b0;
    timeout = W'(400);
    repeat (20) step();
    pwm_cyc(320, 100, 0, 0, 0, 0, 0);
    pwm_cyc(320, 100, 1, 0, 320, 100, 1);

    // Stuck low at timeout 50, then edge/timeout ties
    j = cyc;
    timeout = W'(50);
    pwm = 1'b1;
    push(320, 100, 0, 0, 0, j + 3);
    push(50, 0, 1, 0, 0, j + 53);
    push(50, 0, 1, 0, 0, j + 103);
    repeat (10) step();
    pwm = 1'b0;
    repeat (140) step();
    pwm_cyc(50, 10, 0, 0, 0, 0, 0);
    pwm_cyc(50, 10, 1, 0, 50, 10, 1);
    timeout = W'(400);

    // Enable gating, 40 clocks with 20 high
    gate = 1'b1;
    pwm_cyc(40, 20, 1, 1, 0, 0, 0);
    repeat (3) pwm_cyc(40, 20, 1, 0, 20, 10, 0);
    gate = 1'b0;
    clk_en = 1'b1;

    // Saturation with timeout disabled
    timeout = '0;
    pwm_cyc(600, 300, 1, 1, 0, 0, 0);
    pwm_cyc(600, 300, 1, 0, 511, 300, 1);

    // Reset mid-period
    j = cyc;
    pwm = 1'b1;
    push(511, 300, 0, 0, 0, j + 3);
    repeat (50) step();
    pwm = 1'b0;
    rstn = 1'b0;
    repeat (3) step();
    chk_zero("midrst");
    rstn = 1'b1;
    pwm_cyc(100, 30, 0, 0, 0, 0, 0);
    pwm_cyc(100, 30, 1, 0, 100, 30, 1);
    repeat (20) step();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
